mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12: word-address width driven to the memory (4096 words).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive contended losses after which the instruction port wins.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port i_req  input  1  instruction-fetch request.
REQ-006 SHALL have port i_addr  input  32  fetch byte address.
REQ-007 SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port i_rvalid  output  1  fetch response valid.
REQ-009 SHALL have port i_rdata  output  32  fetch response data.
REQ-010 SHALL have port i_err  output  1  fetch response error (misaligned).
REQ-011 SHALL have port d_req  input  1  data request.
REQ-012 SHALL have port d_we  input  1  data write (1) / read (0).
REQ-013 SHALL have port d_addr  input  32  data byte address.
REQ-014 SHALL have port d_wdata  input  32  store data.
REQ-015 SHALL have ports d_gnt, d_rvalid, d_err (output, 1 each) and d_rdata (output, 32), same meaning as the fetch ports.
REQ-016 SHALL have port mem_we  output  1  memory write enable.
REQ-017 SHALL have port mem_addr  output  AW  memory word address.
REQ-018 SHALL have port mem_wdata  output  32  memory write data.
REQ-019 SHALL have port mem_rdata  input  32  memory read data, combinational from mem_addr.

Function
REQ-020 SHALL grant at most one requester per cycle; i_gnt/d_gnt are combinational from requests and state.
REQ-021 A requester SHALL hold req, addr, we and wdata stable until it sees its gnt; the block does not check this.
REQ-022 In a grant cycle, mem_addr SHALL equal the granted addr[AW+1:2], and mem_we SHALL equal d_we when the data port is granted, otherwise 0.
REQ-023 With no grant, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their previous values.
REQ-024 The granted port's rvalid SHALL assert for exactly one cycle, on the cycle after the grant, carrying mem_rdata registered at the grant edge.
REQ-025 Writes SHALL also return rvalid (acknowledge), with rdata equal to the pre-write memory word.
REQ-026 A request with addr[1:0] != 0 SHALL still be granted, but SHALL force mem_we=0 and SHALL return rvalid with err=1 and rdata=0.
REQ-027 Back-to-back grants to the same port SHALL be allowed, giving one response per cycle.
REQ-028 Arbitration under contention SHALL follow REQ-035/REQ-036; an uncontended request SHALL be granted in the same cycle.
REQ-029 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each cycle where i_req=1 and i_gnt=0; it SHALL clear when i_gnt=1 or i_req=0.
REQ-030 While starve_cnt==STARVE_LIMIT, the instruction port SHALL win contention regardless of mode.

Reset
REQ-031 While rst is high, all gnt, rvalid, err and mem_we SHALL be 0 immediately (asynchronously).
REQ-032 Reset SHALL set rdata outputs, mem_addr and mem_wdata to 0, and clear starve_cnt.
REQ-033 Reset SHALL set the round-robin pointer to favour the data port.
REQ-034 A response pending when reset asserts SHALL be dropped, never presented.

Configuration
REQ-035 With ARB_ROUND_ROBIN_EN defined, contention SHALL go to the port that did not win the previous contended cycle; the pointer SHALL update only on contended cycles.
REQ-036 Without ARB_ROUND_ROBIN_EN, contention SHALL go to the data port (fixed priority), subject to REQ-030, and no pointer register SHALL exist.

Verification
REQ-037 Preload word 5=0xDEADBEEF, then i_req with i_addr=0x14 alone -> i_gnt same cycle, i_rvalid next cycle with i_rdata=0xDEADBEEF, i_err=0.
REQ-038 d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678; next cycle d read of 0x20 -> mem_we=1 for one cycle only; read returns 0x12345678.
REQ-039 i_req and d_req held high for 6 cycles, round-robin build -> grants alternate D,I,D,I,D,I.
REQ-040 Same stimulus, fixed-priority build with STARVE_LIMIT=4 -> D,D,D,D,I,D.
REQ-041 d_req, d_we=1, d_addr=0x22 -> granted, mem_we=0, d_rvalid with d_err=1, d_rdata=0, memory unchanged.
REQ-042 rst asserted on the cycle after a grant -> no rvalid appears; first post-reset contention goes to the data port.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter onto a single
// combinational-read word memory. Each granted request gets exactly one
// response on the following cycle; misaligned requests are granted but
// answered with an error and never write memory.
// An instruction request that keeps losing contention wins once its loss
// count reaches STARVE_LIMIT.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention;
// otherwise the data port has fixed priority and no pointer register exists.
module mem_arbiter #(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve_cnt;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_i_rvalid;
  logic [31:0]   r_i_rdata;
  logic          r_i_err;
  logic          r_d_rvalid;
  logic [31:0]   r_d_rdata;
  logic          r_d_err;

  logic          w_contend;
  logic          w_starved;
  logic          w_i_win;
  logic          w_i_gnt;
  logic          w_d_gnt;
  logic          w_i_mis;
  logic          w_d_mis;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;
  logic          w_mem_we;
  logic          w_unused;

  // Address bits above the memory window are intentionally ignored.
  assign w_unused = ^{i_addr[31:AW+2], d_addr[31:AW+2]};

  assign w_contend = i_req && d_req;
  assign w_starved = (r_starve_cnt == LIMIT);
  assign w_i_mis   = |i_addr[1:0];
  assign w_d_mis   = |d_addr[1:0];

`ifdef ARB_ROUND_ROBIN_EN
  logic r_rr_favour_d;

  assign w_i_win = w_starved || !r_rr_favour_d;

  // Round-robin pointer: after a contended cycle, favour the port that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_favour_d <= 1'b1;
    end else if (w_contend) begin
      r_rr_favour_d <= w_i_win;
    end
  end
`else
  assign w_i_win = w_starved;
`endif

  // Grants are gated by rst so they drop the moment reset asserts.
  assign w_i_gnt = !rst && i_req && (!d_req || w_i_win);
  assign w_d_gnt = !rst && d_req && !(i_req && w_i_win);

  assign w_mem_addr  = w_d_gnt ? d_addr[AW+1:2] :
                       w_i_gnt ? i_addr[AW+1:2] : r_mem_addr;
  assign w_mem_wdata = w_d_gnt ? d_wdata : r_mem_wdata;
  assign w_mem_we    = w_d_gnt && d_we && !w_d_mis;

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign mem_we    = w_mem_we;
  assign i_rvalid  = r_i_rvalid;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

  // Hold the last driven memory address/data so idle cycles do not toggle the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  // Count consecutive contended losses of the instruction port, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_req && !w_i_gnt) begin
      if (!w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Fetch response: capture the pre-edge memory word (zero on misalignment).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_i_err    <= 1'b0;
    end else begin
      r_i_rvalid <= w_i_gnt;
      r_i_err    <= w_i_gnt && w_i_mis;
      if (w_i_gnt) r_i_rdata <= w_i_mis ? 32'h0 : mem_rdata;
    end
  end

  // Data response: writes also acknowledge with the word as it was before the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
      r_d_err    <= 1'b0;
    end else begin
      r_d_rvalid <= w_d_gnt;
      r_d_err    <= w_d_gnt && w_d_mis;
      if (w_d_gnt) r_d_rdata <= w_d_mis ? 32'h0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic.
// A reference model predicts grants, memory bus values and responses each
// cycle; responses go into per-port queues that a monitor drains as the
// DUT presents rvalid. Follows ARB_ROUND_ROBIN_EN like the design.
module tb_mem_arbiter;
  localparam int AW    = 12;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt, i_rvalid, i_err;
  logic [31:0]   i_rdata;
  logic          d_req, d_we;
  logic [31:0]   d_addr, d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;
  resp_t qi[$];
  resp_t qd[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_starve;
  bit            m_fav_d;
  bit            m_ei, m_ed, m_we;
  logic [AW-1:0] m_last_addr;
  logic [AW-1:0] m_w;
  resp_t         m_r;

  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_i_in_reset", i_gnt, 0);
      chk("gnt_d_in_reset", d_gnt, 0);
      chk("mem_we_in_reset", mem_we, 0);
      chk("mem_addr_in_reset", mem_addr, 0);
      m_starve    = 0;
      m_fav_d     = 1;
      m_last_addr = '0;
      qi.delete();
      qd.delete();
    end else begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_ei    = (m_starve == LIMIT) || !m_fav_d;
        m_fav_d = m_ei;
`else
        m_ei = (m_starve == LIMIT);
`endif
        m_ed = !m_ei;
      end else begin
        m_ei = i_req;
        m_ed = d_req;
      end
      chk("i_gnt", i_gnt, m_ei);
      chk("d_gnt", d_gnt, m_ed);
      m_we = m_ed && d_we && (d_addr[1:0] == 2'b00);
      chk("mem_we", mem_we, m_we);
      if (m_ed)      m_last_addr = d_addr[AW+1:2];
      else if (m_ei) m_last_addr = i_addr[AW+1:2];
      chk("mem_addr", mem_addr, m_last_addr);
      if (m_we) chk("mem_wdata", mem_wdata, d_wdata);
      if (m_ei) begin
        m_w     = i_addr[AW+1:2];
        m_r.cyc = cyc;
        m_r.err = (i_addr[1:0] != 2'b00);
        m_r.data = m_r.err ? 32'h0 : ref_mem[m_w];
        qi.push_back(m_r);
      end
      if (m_ed) begin
        m_w     = d_addr[AW+1:2];
        m_r.cyc = cyc;
        m_r.err = (d_addr[1:0] != 2'b00);
        m_r.data = m_r.err ? 32'h0 : ref_mem[m_w];
        qd.push_back(m_r);
        if (m_we) ref_mem[m_w] = d_wdata;
      end
      if (i_req && !m_ei) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                m_starve = 0;
    end
  end

  // ---------------- response monitor ----------------
  bit    mon_ev;
  resp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      chk("i_rvalid_in_reset", i_rvalid, 0);
      chk("d_rvalid_in_reset", d_rvalid, 0);
      chk("i_err_in_reset", i_err, 0);
      chk("d_err_in_reset", d_err, 0);
    end else begin
      mon_ev = (qi.size() > 0) && (qi[0].cyc == cyc - 1);
      chk("i_rvalid", i_rvalid, mon_ev);
      if (mon_ev) begin
        mon_e = qi.pop_front();
        chk("i_rdata", i_rdata, mon_e.data);
        chk("i_err", i_err, mon_e.err);
      end
      mon_ev = (qd.size() > 0) && (qd[0].cyc == cyc - 1);
      chk("d_rvalid", d_rvalid, mon_ev);
      if (mon_ev) begin
        mon_e = qd.pop_front();
        chk("d_rdata", d_rdata, mon_e.data);
        chk("d_err", d_err, mon_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    int w;
    int lo;
    w  = ($urandom_range(0, 7) == 0) ? ((1 << AW) - 1) : $urandom_range(0, 15);
    lo = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
    a  = ($urandom & ~((32'h1 << (AW + 2)) - 1)) | (w << 2) | lo;
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [47:0] seq;
  logic [47:0] exp_seq;
  logic [7:0]  ch;
  logic        last_ig, last_dg;
  logic [31:0] v;

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    for (int k = 0; k < (1 << AW); k++) begin
      v = $urandom;
      mem[k]     = v;
      ref_mem[k] = v;
    end
    mem[5]     = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    step();
    rst = 1'b0;

    // Six cycles of sustained contention.
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = "DIDIDI";
`else
    exp_seq = "DDDDID";
`endif
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h44;
    seq = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ch  = d_gnt ? "D" : (i_gnt ? "I" : "-");
      seq = {seq[39:0], ch};
      step();
    end
    chk("contention_sequence", seq, exp_seq);
    i_req = 0; d_req = 0;
    repeat (2) step();

    // Uncontended fetch of preloaded word 5.
    i_req = 1; i_addr = 32'h14;
    @(negedge clk);
    chk("fetch_gnt_same_cycle", i_gnt, 1);
    step();
    i_req = 0;
    @(negedge clk);
    chk("fetch_rvalid", i_rvalid, 1);
    chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch_err", i_err, 0);
    step();

    // Write then read back.
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("write_mem_we", mem_we, 1);
    step();
    d_we = 0;
    @(negedge clk);
    chk("read_mem_we_low", mem_we, 0);
    step();
    d_req = 0;
    @(negedge clk);
    chk("readback_data", d_rdata, 32'h12345678);
    step();

    // Misaligned store must not touch memory.
    d_req = 1; d_we = 1; d_addr = 32'h22; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("mis_gnt", d_gnt, 1);
    chk("mis_mem_we", mem_we, 0);
    step();
    d_req = 0; d_we = 0;
    @(negedge clk);
    chk("mis_rvalid", d_rvalid, 1);
    chk("mis_err", d_err, 1);
    chk("mis_rdata", d_rdata, 0);
    step();
    d_req = 1; d_addr = 32'h20;
    step();
    d_req = 0;
    @(negedge clk);
    chk("mis_mem_unchanged", d_rdata, 32'h12345678);
    step();

    // Reset right after a grant drops the pending response.
    d_req = 1; d_we = 0; d_addr = 32'h14;
    @(negedge clk);
    chk("pre_reset_gnt", d_gnt, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("dropped_rvalid", d_rvalid, 0);
    @(negedge clk);
    chk("dropped_rvalid_2", d_rvalid, 0);
    step();
    rst = 1'b0;
    i_req = 1; i_addr = 32'h40;
    @(negedge clk);
    chk("post_reset_d_wins", d_gnt, 1);
    chk("post_reset_i_loses", i_gnt, 0);
    step();
    d_req = 0;
    step();
    i_req = 0;
    repeat (2) step();

    // Random traffic; a requester holds its request until granted.
    last_ig = 1'b1;
    last_dg = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (!(i_req && !last_ig)) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = rnd_addr();
      end
      if (!(d_req && !last_dg)) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = rnd_addr();
        d_wdata = $urandom;
      end
      @(negedge clk);
      last_ig = i_gnt;
      last_dg = d_gnt;
      step();
    end
    i_req = 0; d_req = 0;
    repeat (3) step();
    @(negedge clk);
    chk("i_queue_drained", qi.size(), 0);
    chk("d_queue_drained", qd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
